// File: rtl/dense_bwd_sched_pkg.sv
// Shared training constants for the dense backward-pass scheduler.
package dense_bwd_sched_pkg;

    localparam int N_LEN = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRANS,
        S_GAP1,
        S_MM,
        S_GAP2,
        S_UPD,
        S_FIN,
        S_ABORT
    } state_t;

endpackage

// File: rtl/dense_bwd_sched_if.sv
// Controller handshake, engine run/valid and shared RAM/buffer ports of the scheduler.
interface dense_bwd_sched_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int W          = 8 * dense_bwd_sched_pkg::N_LEN
) ();

    logic                  start;
    logic                  skip_upd;
    logic                  busy;
    logic                  done;
    logic                  err;

    logic                  trans_run;
    logic                  mm_run;
    logic                  upd_run;
    logic                  trans_valid;
    logic                  mm_valid;
    logic                  upd_valid;

    logic [ADDR_WIDTH-1:0] trans_raddr;
    logic [ADDR_WIDTH-1:0] trans_waddr;
    logic [W-1:0]          trans_wdata;
    logic [ADDR_WIDTH-1:0] upd_raddr;
    logic [ADDR_WIDTH-1:0] upd_waddr;
    logic [W-1:0]          upd_wdata;
    logic                  upd_we;

    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [W-1:0]          w_wdata;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] t_waddr;
    logic [W-1:0]          t_wdata;
    logic                  t_we;

    modport master (
        input  start, skip_upd,
        output busy, done, err,
        output trans_run, mm_run, upd_run,
        input  trans_valid, mm_valid, upd_valid,
        input  trans_raddr, trans_waddr, trans_wdata,
        input  upd_raddr, upd_waddr, upd_wdata, upd_we,
        output w_raddr, w_waddr, w_wdata, w_we,
        output t_waddr, t_wdata, t_we
    );

    modport slave (
        output start, skip_upd,
        input  busy, done, err,
        input  trans_run, mm_run, upd_run,
        output trans_valid, mm_valid, upd_valid,
        output trans_raddr, trans_waddr, trans_wdata,
        output upd_raddr, upd_waddr, upd_wdata, upd_we,
        input  w_raddr, w_waddr, w_wdata, w_we,
        input  t_waddr, t_wdata, t_we
    );

endinterface

// File: rtl/dense_bwd_sched_phase_timer.sv
// Per-phase cycle counter; flags the last permitted cycle of a phase.
module phase_timer #(
    parameter  int TIMEOUT = 4096,
    localparam int CW      = $clog2(TIMEOUT) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          expired
);

    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expired = en && (count == LAST);

endmodule

// File: rtl/dense_bwd_sched.sv
// Backward-pass phase sequencer: transpose -> matmul -> weight update, with RAM port muxing.
module dense_bwd_sched
    import dense_bwd_sched_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DENSE_DATA_N = 8,
    parameter int TRANS_LAT    = 11,
    parameter int TIMEOUT      = 4096
) (
    input logic               clk,
    input logic               rst,
    dense_bwd_sched_if.master bus
);

    localparam int W  = DENSE_DATA_N * N_LEN;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TRANS_LAT_C = CW'(TRANS_LAT);

    state_t          state_q, state_d;
    logic            skip_q;
    logic            err_q;
    logic            in_phase;
    logic            expired;
    logic [CW-1:0]   phase_cnt;

    logic [ADDR_WIDTH-1:0] w_raddr_c, w_waddr_c, t_waddr_c;
    logic [W-1:0]          w_wdata_c, t_wdata_c;

    assign in_phase = (state_q == S_TRANS) || (state_q == S_MM) || (state_q == S_UPD);

    // Counter sits at zero in every non-phase state, so each phase starts from 0.
    phase_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_phase),
        .en      (in_phase),
        .count   (phase_cnt),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            skip_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && bus.start) begin
                skip_q <= bus.skip_upd;
                err_q  <= 1'b0;
            end else if (state_d == S_ABORT) begin
                err_q  <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_TRANS;
            S_TRANS: if (bus.trans_valid) state_d = S_GAP1;
                     else if (expired)    state_d = S_ABORT;
            S_GAP1:  state_d = S_MM;
            S_MM:    if (bus.mm_valid)    state_d = S_GAP2;
                     else if (expired)    state_d = S_ABORT;
            S_GAP2:  state_d = skip_q ? S_FIN : S_UPD;
            S_UPD:   if (bus.upd_valid)   state_d = S_FIN;
                     else if (expired)    state_d = S_ABORT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_raddr_c = '0;
        w_waddr_c = '0;
        w_wdata_c = '0;
        t_waddr_c = '0;
        t_wdata_c = '0;
        if (state_q == S_TRANS) begin
            w_raddr_c = bus.trans_raddr;
            t_waddr_c = bus.trans_waddr;
            t_wdata_c = bus.trans_wdata;
        end else if (state_q == S_UPD) begin
            w_raddr_c = bus.upd_raddr;
            w_waddr_c = bus.upd_waddr;
            w_wdata_c = bus.upd_wdata;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_FIN);
    assign bus.err       = err_q;
    assign bus.trans_run = (state_q == S_TRANS);
    assign bus.mm_run    = (state_q == S_MM);
    assign bus.upd_run   = (state_q == S_UPD);

    assign bus.w_raddr   = w_raddr_c;
    assign bus.w_waddr   = w_waddr_c;
    assign bus.w_wdata   = w_wdata_c;
    assign bus.w_we      = (state_q == S_UPD) && bus.upd_we;
    assign bus.t_waddr   = t_waddr_c;
    assign bus.t_wdata   = t_wdata_c;
    // Skip pipeline-fill cycles and the held final address on the valid cycle.
    assign bus.t_we      = (state_q == S_TRANS) && (phase_cnt >= TRANS_LAT_C) && !bus.trans_valid;

endmodule
